led_seq_ctrl: RTL and testbench
===============================

# led_seq_ctrl

Four-requester LED pattern scheduler for the 4-LED bank. It arbitrates pattern requests from up to four sources (key handlers, UART command decoder, etc.) with round-robin fairness. It then runs the granted pattern for a requested number of steps, one step per tick of an internal prescaler. It owns the `led` outputs outright; requesters never drive LEDs directly.

## Interface
- `TICK_DIV`, default 10_000_000: sys_clk cycles per pattern step (0.2 s at 50 MHz); legal range 2..2^24-1.
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  asynchronous reset, active-high; one clock; reset is asynchronous and active-high.
- `req`  in  4  per-requester request; held high until the matching `gnt` bit is seen.
- `req_mode`  in  8  2 bits per requester (`[2i+1:2i]`): 0 rotate-left, 1 rotate-right, 2 blink, 3 binary count.
- `req_steps`  in  16  4 bits per requester (`[4i+3:4i]`): steps to run; 0 means 16.
- `abort`  in  1  synchronous stop of the running pattern.
- `gnt`  out  4  one-hot, one-cycle grant pulse.
- `busy`  out  1  high while a pattern is running.
- `done`  out  1  one-cycle pulse on normal completion.
- `led`  out  4  LED drive, 1 = on.

## Operation
- **Reset values:** `led`=0001, `gnt`=0000, `busy`=0, `done`=0, prescaler=0, remaining=0, RR pointer=0, state IDLE.
- **FSM:** two states, IDLE and RUN.
- **IDLE, no request or `abort` high:** hold outputs. `led` keeps its last value.
- **IDLE, any `req` high and `abort` low:**
  - Pick the first set bit scanning from the RR pointer upward, mod 4.
  - On that edge:
    - `gnt[i]`←1.
    - Latch mode i.
    - Latch steps i (0 maps to 16).
    - Prescaler←0.
    - `busy`←1.
    - RR pointer←(i+1) mod 4.
    - State←RUN.
  - `led` is initialised by mode: rotate-left 0001, rotate-right 1000, blink 1111, count 0000.
- **RUN, on each tick** (prescaler reaches TICK_DIV-1; prescaler wraps to 0):
  - Apply one step:
    - rotate-left `{led[2:0],led[3]}`.
    - rotate-right `{led[0],led[3:1]}`.
    - blink `~led`.
    - count `led+1`, wrapping 1111→0000.
  - Remaining decrements.
  - On the step that makes remaining 0, on the same edge: `done`←1, `busy`←0, state←IDLE.
- **RUN, `abort` high:** on the next edge state←IDLE, `busy`←0, `led`←0001, prescaler←0. No `done`. `abort` wins over a coincident tick.
- **`abort` in IDLE:** no effect except blocking a grant in that cycle.
- **`req` in RUN:** ignored; requests wait, with no queueing beyond the held `req` level.
- **`req_mode`/`req_steps` sampling:** sampled only on the grant edge; later changes have no effect.
- **Reset mid-RUN:** immediate return to reset values; the pending requester is not granted.

## Timing
- **Grant:** `req` sampled high in IDLE at edge k gives `gnt`, `busy` and initial `led` all valid in cycle k+1.
- **Step cadence:** first step at edge k+TICK_DIV; subsequent steps every TICK_DIV cycles.
- **Total run time:** N steps occupy N·TICK_DIV cycles from the grant edge. `done` is high in the cycle after the last-step edge, together with the final `led` value.
- **Back-to-back grants:** the earliest next grant is the edge ending the `done` cycle, so `gnt` rises one cycle after `done`.
- **Output registers:** `gnt` and `done` are exactly one cycle wide. All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use TICK_DIV=4.
- **Reset:** assert `sys_rst` mid-run → `led`=0001, `busy`=0, `gnt`=0 immediately (asynchronously). After release, stay idle with `req`=0.
- **Rotate-left, 3 steps:**
  - Stimulus: `req`=0001, mode 0, steps 3.
  - Required: `gnt`=0001 for one cycle, `led`=0001.
  - Then `led`=0010, 0100, 1000 at +4, +8, +12 cycles.
  - `done` is pulsed with 1000, then `busy`=0.
- **Round robin:**
  - Stimulus: `req`=1111 held, each run 1 step.
  - Required: grants 0001, 0010, 0100, 1000, 0001 in order.
  - Each `gnt` comes one cycle after the previous `done`.
- **Wrap and zero-step:**
  - Stimulus: count mode, steps 0.
  - Required: 16 steps, `led` 0000→0001→…→1111→0000.
  - `done` after 64 cycles with `led`=0000.
- **Abort:**
  - Stimulus: blink, steps 8; assert `abort` in the cycle where a tick is due at step 3.
  - Required: `led`=0001 and `busy`=0 next cycle; `done` never pulses.
  - With `req`=0010 and `abort` high together in IDLE, no `gnt`.
- **Request-while-busy:**
  - Stimulus: requester 2 asserts during requester 0's run, changing `req_mode` before the grant.
  - Required: requester 2 is granted only after `done`, using mode values present at its grant edge.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// Four-requester LED pattern scheduler: round-robin grant, then a pattern runs for a
// latched number of prescaled steps on the 4-LED bank.
module led_seq_ctrl #(
    parameter int unsigned TICK_DIV = 10_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  req,
    input  logic [7:0]  req_mode,
    input  logic [15:0] req_steps,
    input  logic        abort,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic        done,
    output logic [3:0]  led
);

    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

    typedef enum logic {StIdle, StRun} state_t;

    state_t      state;
    logic [1:0]  rr_ptr;
    logic [1:0]  mode;
    logic [4:0]  remaining;
    logic [23:0] prescaler;

    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic [1:0]  scan_idx;
    logic [1:0]  pick_mode;
    logic [3:0]  pick_steps;
    logic [3:0]  led_init;
    logic [3:0]  led_step;
    logic        tick;

    // Scan downward so the requester closest above rr_ptr is the one left standing.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        scan_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr_ptr + 2'(k);
            if (req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign pick_mode  = req_mode[{pick_idx, 1'b0} +: 2];
    assign pick_steps = req_steps[{pick_idx, 2'b00} +: 4];
    assign tick       = (prescaler == TICK_LAST);

    always_comb begin
        led_init = 4'b0001;
        unique case (pick_mode)
            2'd0: led_init = 4'b0001;
            2'd1: led_init = 4'b1000;
            2'd2: led_init = 4'b1111;
            2'd3: led_init = 4'b0000;
        endcase
    end

    always_comb begin
        led_step = led;
        unique case (mode)
            2'd0: led_step = {led[2:0], led[3]};
            2'd1: led_step = {led[0], led[3:1]};
            2'd2: led_step = ~led;
            2'd3: led_step = led + 4'd1;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= StIdle;
            rr_ptr    <= 2'd0;
            mode      <= 2'd0;
            remaining <= 5'd0;
            prescaler <= 24'd0;
            gnt       <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            led       <= 4'b0001;
        end else begin
            gnt  <= 4'b0000;
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (pick_valid && !abort) begin
                        gnt       <= 4'b0001 << pick_idx;
                        mode      <= pick_mode;
                        remaining <= {pick_steps == 4'd0, pick_steps};
                        prescaler <= 24'd0;
                        busy      <= 1'b1;
                        rr_ptr    <= pick_idx + 2'd1;
                        led       <= led_init;
                        state     <= StRun;
                    end
                end
                StRun: begin
                    if (abort) begin
                        state     <= StIdle;
                        busy      <= 1'b0;
                        led       <= 4'b0001;
                        prescaler <= 24'd0;
                    end else if (tick) begin
                        prescaler <= 24'd0;
                        led       <= led_step;
                        remaining <= remaining - 5'd1;
                        if (remaining == 5'd1) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= StIdle;
                        end
                    end else begin
                        prescaler <= prescaler + 24'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl with TICK_DIV=4: expected output events are queued
// with the stimulus and popped by a monitor that watches for grant/done/led/busy changes.
module tb_led_seq_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [7:0]  req_mode = 8'h00;
    logic [15:0] req_steps = 16'h0000;
    logic        abort = 1'b0;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [3:0]  led;

    led_seq_ctrl #(.TICK_DIV(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req       (req),
        .req_mode  (req_mode),
        .req_steps (req_steps),
        .abort     (abort),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .led       (led)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic       done;
        logic       busy;
        logic [3:0] led;
    } ev_t;

    ev_t   exp_q[$];
    int    gap_q[$];
    string name_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    logic [3:0] prev_led  = 4'b0001;
    logic       prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // gap = cycles since the previous observed event, -1 when not checked
    task automatic expect_ev(input string name, input logic [3:0] g, input logic d,
                             input logic b, input logic [3:0] l, input int gap);
        ev_t e;
        e.gnt  = g;
        e.done = d;
        e.busy = b;
        e.led  = l;
        exp_q.push_back(e);
        gap_q.push_back(gap);
        name_q.push_back(name);
    endtask

    task automatic step_to(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        ev_t   obs;
        ev_t   e;
        int    g;
        string nm;
        forever begin
            @(negedge sys_clk);
            cyc++;
            obs.gnt  = gnt;
            obs.done = done;
            obs.busy = busy;
            obs.led  = led;
            if (gnt != 4'b0000 || done || led != prev_led || busy != prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got gnt=%b done=%b busy=%b led=%b, required none",
                             gnt, done, busy, led);
                end else begin
                    e  = exp_q.pop_front();
                    g  = gap_q.pop_front();
                    nm = name_q.pop_front();
                    check(nm, 32'(obs), 32'(e));
                    if (g >= 0) check({nm, "_gap"}, cyc - last_cyc, g);
                end
                last_cyc = cyc;
            end
            prev_led  = led;
            prev_busy = busy;
        end
    end

    initial begin
        #2 sys_rst = 1'b1;
        step_to(2);
        check("reset_led", led, 4'b0001);
        check("reset_busy", busy, 0);
        check("reset_gnt", gnt, 0);
        check("reset_done", done, 0);
        sys_rst = 1'b0;
        step_to(2);

        // Rotate-left, 3 steps from requester 0
        expect_ev("rl_grant", 4'b0001, 0, 1, 4'b0001, -1);
        expect_ev("rl_step1", 4'b0000, 0, 1, 4'b0010, 4);
        expect_ev("rl_step2", 4'b0000, 0, 1, 4'b0100, 4);
        expect_ev("rl_done",  4'b0000, 1, 0, 4'b1000, 4);
        req_mode  = 8'h00;
        req_steps = 16'h0003;
        req       = 4'b0001;
        step_to(1);
        req = 4'b0000;
        step_to(15);

        // Idle reset returns led to 0001 and clears the RR pointer
        expect_ev("rst_idle", 4'b0000, 0, 0, 4'b0001, -1);
        sys_rst = 1'b1;
        step_to(1);
        sys_rst = 1'b0;
        step_to(2);

        // Round robin, all four held, one step each
        expect_ev("rr_g0", 4'b0001, 0, 1, 4'b0001, -1);
        expect_ev("rr_d0", 4'b0000, 1, 0, 4'b0010, 4);
        expect_ev("rr_g1", 4'b0010, 0, 1, 4'b0001, 1);
        expect_ev("rr_d1", 4'b0000, 1, 0, 4'b0010, 4);
        expect_ev("rr_g2", 4'b0100, 0, 1, 4'b0001, 1);
        expect_ev("rr_d2", 4'b0000, 1, 0, 4'b0010, 4);
        expect_ev("rr_g3", 4'b1000, 0, 1, 4'b0001, 1);
        expect_ev("rr_d3", 4'b0000, 1, 0, 4'b0010, 4);
        expect_ev("rr_g4", 4'b0001, 0, 1, 4'b0001, 1);
        expect_ev("rr_d4", 4'b0000, 1, 0, 4'b0010, 4);
        req_mode  = 8'h00;
        req_steps = 16'h1111;
        req       = 4'b1111;
        step_to(21);
        req = 4'b0000;
        step_to(10);

        // Count mode, steps 0 => 16 steps, wraps back to 0000
        expect_ev("cnt_grant", 4'b0010, 0, 1, 4'b0000, -1);
        for (int i = 1; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            expect_ev($sformatf("cnt_step%0d", i), 4'b0000, 0, 1, v, 4);
        end
        expect_ev("cnt_done", 4'b0000, 1, 0, 4'b0000, 4);
        req_mode  = 8'h0C;
        req_steps = 16'h0000;
        req       = 4'b0010;
        step_to(1);
        req = 4'b0000;
        step_to(70);

        // Blink, 8 steps, aborted when step 3 is due
        expect_ev("ab_grant", 4'b0100, 0, 1, 4'b1111, -1);
        expect_ev("ab_step1", 4'b0000, 0, 1, 4'b0000, 4);
        expect_ev("ab_step2", 4'b0000, 0, 1, 4'b1111, 4);
        expect_ev("ab_stop",  4'b0000, 0, 0, 4'b0001, 4);
        req_mode  = 8'h20;
        req_steps = 16'h0800;
        req       = 4'b0100;
        step_to(1);
        req = 4'b0000;
        step_to(11);
        abort = 1'b1;
        step_to(1);
        check("abort_busy", busy, 0);
        check("abort_led", led, 4'b0001);
        abort = 1'b0;
        step_to(20);

        // abort blocks a grant in idle
        abort = 1'b1;
        req   = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step_to(1);
            check("idle_abort_gnt", gnt, 0);
            check("idle_abort_busy", busy, 0);
        end
        req   = 4'b0000;
        abort = 1'b0;
        step_to(3);

        // Request while busy; requester 2's mode changes before its grant and after it
        expect_ev("rwb_g0",   4'b0001, 0, 1, 4'b0001, -1);
        expect_ev("rwb_s0",   4'b0000, 0, 1, 4'b0010, 4);
        expect_ev("rwb_d0",   4'b0000, 1, 0, 4'b0100, 4);
        expect_ev("rwb_g2",   4'b0100, 0, 1, 4'b1000, 1);
        expect_ev("rwb_d2",   4'b0000, 1, 0, 4'b0100, 4);
        req_mode  = 8'h00;
        req_steps = 16'h0002;
        req       = 4'b0001;
        step_to(1);
        req = 4'b0000;
        step_to(2);
        req       = 4'b0100;
        req_steps = 16'h0102;
        req_mode  = 8'h00;
        step_to(3);
        req_mode = 8'h10;
        step_to(4);
        req = 4'b0000;
        step_to(1);
        req_mode = 8'h30;
        step_to(10);

        // Reset mid-run with the requester still holding req
        expect_ev("mr_grant", 4'b1000, 0, 1, 4'b0001, -1);
        expect_ev("mr_step1", 4'b0000, 0, 1, 4'b0010, 4);
        expect_ev("mr_reset", 4'b0000, 0, 0, 4'b0001, 1);
        req_mode  = 8'h00;
        req_steps = 16'h4000;
        req       = 4'b1000;
        step_to(6);
        #1 sys_rst = 1'b1;
        #1;
        check("midrst_led", led, 4'b0001);
        check("midrst_busy", busy, 0);
        check("midrst_gnt", gnt, 0);
        step_to(2);
        req = 4'b0000;
        step_to(1);
        sys_rst = 1'b0;
        step_to(10);
        check("post_rst_gnt", gnt, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_led", led, 4'b0001);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
